pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 77 +++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, jump/branch redirect with a one-cycle
// bubble after boot and after every accepted redirect, saturating redirect counter.
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        branch,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [3:0]  pc_upper,
  output logic        fetch_valid,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] branch_tgt;
  logic        redirect;
  logic        unused_bits;

  // Word offset scaled to bytes; the top two offset bits fall off the 32-bit sum.
  assign branch_tgt  = pc_plus4 + {branch_offset[29:0], 2'b00};
  assign redirect    = (state_q == RUN) && !stall && (jump || branch);
  assign unused_bits = ^{jump_addr[1:0], branch_offset[31:30]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = (jump || branch) ? FLUSH : RUN;
        FLUSH:   state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (redirect) begin
      pc_d = jump ? {jump_addr[31:2], 2'b00} : branch_tgt;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if ((state_q == RUN) && !stall) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    pc             = pc_q;
    pc_plus4       = pc_q + 32'd4;
    pc_upper       = pc_plus4[31:28];
    fetch_valid    = (state_q == RUN);
    redirect_count = cnt_q;
  end

endmodule
